ibex_rf_wr_arbiter: RTL and testbench
=====================================

Name: ibex_rf_wr_arbiter

Overview:
Shares the single register-file write port between three producers: LSU load data, ID/EX results and a multicycle auxiliary unit (e.g. iterative divider).
- Sits between the execute/LSU datapath and the register file, replacing a fixed two-way write mux.
- Keeps a per-register pending-write scoreboard that ID uses to detect read-after-write hazards.
- Prevents starvation of the auxiliary unit with a bounded stall counter.

Parameters:
AuxMaxStall, 4, consecutive cycles aux may be refused before it gains priority over EX (legal range 1..15).

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
lsu_we_i  in  1  LSU load write request; cannot be back-pressured
lsu_waddr_i  in  5  LSU destination register
lsu_wdata_i  in  32  LSU load data
ex_valid_i  in  1  EX result write request
ex_waddr_i  in  5  EX destination register
ex_wdata_i  in  32  EX result
ex_ready_o  out  1  EX write accepted this cycle
aux_valid_i  in  1  aux result write request
aux_waddr_i  in  5  aux destination register
aux_wdata_i  in  32  aux result
aux_ready_o  out  1  aux write accepted this cycle
issue_i  in  1  ID issues an instruction that will write a register
issue_waddr_i  in  5  destination of the issued instruction
raddr_a_i  in  5  ID read port A address
raddr_b_i  in  5  ID read port B address
hazard_o  out  1  a source register has a pending write
rf_we_o  out  1  register file write enable
rf_waddr_o  out  5  register file write address
rf_wdata_o  out  32  register file write data
pending_cnt_o  out  6  number of registers with a pending write

Behaviour:
- Reset is asynchronous and active-low. On reset:
  - scoreboard sb_q = 0, stall counter = 0, pending_cnt_o = 0.
  - All outputs are combinational from that state and the inputs. With all requests low they read rf_we_o = 0, ex_ready_o = 0, aux_ready_o = 0, hazard_o = 0.
- Grant is combinational with zero latency; a request is accepted in the same cycle it is granted.
  - The arbiter holds no data; the requester keeps valid/addr/data stable until it sees ready (AXI-style).
  - Dropping valid before ready is illegal; assertion required.
- Priority:
  - lsu_we_i always wins.
  - Among EX and aux: EX wins unless aux_urgent = (stall_cnt_q == AuxMaxStall); then aux wins.
- ex_ready_o = ex_valid_i & ~lsu_we_i & ~(aux_valid_i & aux_urgent).
- aux_ready_o = aux_valid_i & ~lsu_we_i & (~ex_valid_i | aux_urgent).
- At most one of lsu_we_i, ex_ready_o, aux_ready_o is granted per cycle; assert one-hot0.
- rf_we_o = OR of all grants; rf_waddr_o / rf_wdata_o are muxed from the granted source; both are 0 when there is no grant.
- A grant with waddr == 0 still handshakes, but rf_we_o is forced to 0 (x0 is never written).
- Stall counter (4 bits):
  - Increments when aux_valid_i & ~aux_ready_o, saturating at AuxMaxStall.
  - Clears when aux_ready_o is high or aux_valid_i is low.
- Scoreboard, 32 bits:
  - Bit 0 is hard-wired to 0.
  - Set on issue_i for issue_waddr_i != 0.
  - Cleared by any granted write to that address, including a grant while rf_we_o is suppressed.
  - Set and clear of the same register in one cycle: set wins, because the new instruction owns the register.
  - Set of an already-set bit is legal (WAW) and the bit stays 1.
- hazard_o = sb_q[raddr_a_i] | sb_q[raddr_b_i], from registered state only. Same-cycle writeback is resolved by ID forwarding, not here.
- pending_cnt_o = popcount(sb_q), registered-state based.
- Reset mid-operation discards all pending bits and the stall count. Producers are reset in the same domain, so no handshake completes across reset.

Test Plan:
- Reset, then all requests idle -> rf_we_o=0, hazard_o=0, pending_cnt_o=0, ex_ready_o=aux_ready_o=0.
- issue_i with waddr=5; next cycle raddr_a_i=5 -> hazard_o=1, pending_cnt_o=1. EX writes x5=0xDEADBEEF with ex_valid_i=1 -> ex_ready_o=1, rf_we_o=1, rf_waddr_o=5, rf_wdata_o=0xDEADBEEF. Next cycle -> hazard_o=0, pending_cnt_o=0.
- lsu_we_i and ex_valid_i together, addrs 3 and 7 -> rf_waddr_o=3, ex_ready_o=0. Next cycle with LSU idle -> rf_waddr_o=7, ex_ready_o=1.
- AuxMaxStall=4; ex_valid_i held high and aux_valid_i high for 6 cycles -> aux_ready_o=0 in cycles 0-3 and 1 in cycle 4 (ex_ready_o=0 that cycle); stall counter then clears.
- issue_i waddr=9 in the same cycle as an EX write to x9 with sb[9] already set -> sb[9] remains 1, pending_cnt_o unchanged.
- EX write to x0 with valid -> ex_ready_o=1, rf_we_o=0; issue to x0 -> pending_cnt_o stays 0.

Source files
------------

// File: rtl/ibex_rf_wr_arbiter.sv
// Register-file write-port arbiter (LSU > EX/aux) with pending-write scoreboard for RAW hazard detection.
// Latency: grants are combinational (same-cycle accept); scoreboard, stall count and pending count update on the next edge.
// Backpressure: LSU is never stalled; EX/aux hold valid/addr/data until ready; aux gains priority after AuxMaxStall refusals.
module ibex_rf_wr_arbiter #(
    parameter int unsigned AuxMaxStall = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        lsu_we_i,
    input  logic [4:0]  lsu_waddr_i,
    input  logic [31:0] lsu_wdata_i,
    input  logic        ex_valid_i,
    input  logic [4:0]  ex_waddr_i,
    input  logic [31:0] ex_wdata_i,
    output logic        ex_ready_o,
    input  logic        aux_valid_i,
    input  logic [4:0]  aux_waddr_i,
    input  logic [31:0] aux_wdata_i,
    output logic        aux_ready_o,
    input  logic        issue_i,
    input  logic [4:0]  issue_waddr_i,
    input  logic [4:0]  raddr_a_i,
    input  logic [4:0]  raddr_b_i,
    output logic        hazard_o,
    output logic        rf_we_o,
    output logic [4:0]  rf_waddr_o,
    output logic [31:0] rf_wdata_o,
    output logic [5:0]  pending_cnt_o
);

    localparam logic [3:0] StallMax = 4'(AuxMaxStall);

    logic [3:0]  stall_cnt_q, stall_cnt_d;
    logic [31:0] sb_q, sb_d;
    logic        aux_urgent;
    logic        grant_any;
    logic [4:0]  gnt_addr;
    logic [31:0] gnt_data;

    // aux overtakes EX only once it has been refused AuxMaxStall cycles in a row
    assign aux_urgent  = (stall_cnt_q == StallMax);
    assign ex_ready_o  = ex_valid_i & ~lsu_we_i & ~(aux_valid_i & aux_urgent);
    assign aux_ready_o = aux_valid_i & ~lsu_we_i & (~ex_valid_i | aux_urgent);

    // Select the granted source; address/data read zero when nothing is granted
    always_comb begin
        grant_any = 1'b0;
        gnt_addr  = '0;
        gnt_data  = '0;
        if (lsu_we_i) begin
            grant_any = 1'b1;
            gnt_addr  = lsu_waddr_i;
            gnt_data  = lsu_wdata_i;
        end else if (ex_ready_o) begin
            grant_any = 1'b1;
            gnt_addr  = ex_waddr_i;
            gnt_data  = ex_wdata_i;
        end else if (aux_ready_o) begin
            grant_any = 1'b1;
            gnt_addr  = aux_waddr_i;
            gnt_data  = aux_wdata_i;
        end
    end

    // x0 writes still handshake but never reach the register file
    assign rf_we_o    = grant_any & (gnt_addr != 5'd0);
    assign rf_waddr_o = gnt_addr;
    assign rf_wdata_o = gnt_data;

    // Count consecutive aux refusals, saturating; any accept or idle cycle restarts the count
    always_comb begin
        stall_cnt_d = '0;
        if (aux_valid_i && !aux_ready_o) begin
            stall_cnt_d = (stall_cnt_q == StallMax) ? stall_cnt_q : stall_cnt_q + 4'd1;
        end
    end

    // Scoreboard next state: clear on any grant, then set on issue so a new owner wins the tie
    always_comb begin
        sb_d = sb_q;
        if (grant_any) begin
            sb_d[gnt_addr] = 1'b0;
        end
        if (issue_i) begin
            sb_d[issue_waddr_i] = 1'b1;
        end
        sb_d[0] = 1'b0;
    end

    // State registers; reset discards all pending writes and stall history
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt_q <= '0;
            sb_q        <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            sb_q        <= sb_d;
        end
    end

    // Hazard looks only at registered state; same-cycle writeback is forwarded in ID
    assign hazard_o = sb_q[raddr_a_i] | sb_q[raddr_b_i];

    // Population count of outstanding writes (bit 0 is always clear)
    always_comb begin
        pending_cnt_o = '0;
        for (int i = 1; i < 32; i++) begin
            pending_cnt_o = pending_cnt_o + 6'(sb_q[i]);
        end
    end

    a_grant_onehot0: assert property (@(posedge clk_i) disable iff (!rst_ni)
        $onehot0({lsu_we_i, ex_ready_o, aux_ready_o}));

    a_ex_valid_held: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (ex_valid_i && !ex_ready_o) |=> ex_valid_i);

    a_aux_valid_held: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (aux_valid_i && !aux_ready_o) |=> aux_valid_i);

endmodule

// File: tb/tb_ibex_rf_wr_arbiter.sv
module tb_ibex_rf_wr_arbiter;

    localparam int MAX_STALL = 4;

    logic        clk_i;
    logic        rst_ni;
    logic        lsu_we_i;
    logic [4:0]  lsu_waddr_i;
    logic [31:0] lsu_wdata_i;
    logic        ex_valid_i;
    logic [4:0]  ex_waddr_i;
    logic [31:0] ex_wdata_i;
    logic        ex_ready_o;
    logic        aux_valid_i;
    logic [4:0]  aux_waddr_i;
    logic [31:0] aux_wdata_i;
    logic        aux_ready_o;
    logic        issue_i;
    logic [4:0]  issue_waddr_i;
    logic [4:0]  raddr_a_i;
    logic [4:0]  raddr_b_i;
    logic        hazard_o;
    logic        rf_we_o;
    logic [4:0]  rf_waddr_o;
    logic [31:0] rf_wdata_o;
    logic [5:0]  pending_cnt_o;

    int n_checks = 0;
    int n_fail   = 0;

    ibex_rf_wr_arbiter #(.AuxMaxStall(MAX_STALL)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .lsu_we_i(lsu_we_i), .lsu_waddr_i(lsu_waddr_i), .lsu_wdata_i(lsu_wdata_i),
        .ex_valid_i(ex_valid_i), .ex_waddr_i(ex_waddr_i), .ex_wdata_i(ex_wdata_i), .ex_ready_o(ex_ready_o),
        .aux_valid_i(aux_valid_i), .aux_waddr_i(aux_waddr_i), .aux_wdata_i(aux_wdata_i), .aux_ready_o(aux_ready_o),
        .issue_i(issue_i), .issue_waddr_i(issue_waddr_i),
        .raddr_a_i(raddr_a_i), .raddr_b_i(raddr_b_i), .hazard_o(hazard_o),
        .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
        .pending_cnt_o(pending_cnt_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle;
        #2;
    endtask

    task automatic idle;
        lsu_we_i = 0; lsu_waddr_i = 0; lsu_wdata_i = 0;
        ex_valid_i = 0; ex_waddr_i = 0; ex_wdata_i = 0;
        aux_valid_i = 0; aux_waddr_i = 0; aux_wdata_i = 0;
        issue_i = 0; issue_waddr_i = 0;
        raddr_a_i = 0; raddr_b_i = 0;
    endtask

    task automatic test_reset;
        rst_ni = 1'b0;
        idle();
        #12;
        n_checks++; if (rf_we_o !== 1'b0) begin n_fail++; $display("FAIL reset_rf_we: got %b want 0", rf_we_o); end
        n_checks++; if (hazard_o !== 1'b0) begin n_fail++; $display("FAIL reset_hazard: got %b want 0", hazard_o); end
        n_checks++; if (pending_cnt_o !== 6'd0) begin n_fail++; $display("FAIL reset_pending: got %0d want 0", pending_cnt_o); end
        n_checks++; if ({ex_ready_o, aux_ready_o} !== 2'b00) begin n_fail++; $display("FAIL reset_ready: got %b want 00", {ex_ready_o, aux_ready_o}); end
        tick();
        rst_ni = 1'b1;
        tick();
    endtask

    task automatic test_issue_ex;
        issue_i = 1; issue_waddr_i = 5; raddr_a_i = 5;
        settle();
        n_checks++; if (hazard_o !== 1'b0) begin n_fail++; $display("FAIL issue_same_cycle_hazard: got %b want 0", hazard_o); end
        tick();
        issue_i = 0;
        settle();
        n_checks++; if (hazard_o !== 1'b1) begin n_fail++; $display("FAIL issue_hazard: got %b want 1", hazard_o); end
        n_checks++; if (pending_cnt_o !== 6'd1) begin n_fail++; $display("FAIL issue_pending: got %0d want 1", pending_cnt_o); end
        tick();
        ex_valid_i = 1; ex_waddr_i = 5; ex_wdata_i = 32'hDEADBEEF;
        settle();
        n_checks++; if (ex_ready_o !== 1'b1) begin n_fail++; $display("FAIL ex_write_ready: got %b want 1", ex_ready_o); end
        n_checks++; if (rf_we_o !== 1'b1) begin n_fail++; $display("FAIL ex_write_we: got %b want 1", rf_we_o); end
        n_checks++; if (rf_waddr_o !== 5'd5) begin n_fail++; $display("FAIL ex_write_addr: got %0d want 5", rf_waddr_o); end
        n_checks++; if (rf_wdata_o !== 32'hDEADBEEF) begin n_fail++; $display("FAIL ex_write_data: got %h want deadbeef", rf_wdata_o); end
        tick();
        ex_valid_i = 0;
        settle();
        n_checks++; if (hazard_o !== 1'b0) begin n_fail++; $display("FAIL ex_write_hazard_clear: got %b want 0", hazard_o); end
        n_checks++; if (pending_cnt_o !== 6'd0) begin n_fail++; $display("FAIL ex_write_pending_clear: got %0d want 0", pending_cnt_o); end
        tick();
        idle();
    endtask

    task automatic test_lsu_priority;
        lsu_we_i = 1; lsu_waddr_i = 3; lsu_wdata_i = 32'h3333;
        ex_valid_i = 1; ex_waddr_i = 7; ex_wdata_i = 32'h7777;
        settle();
        n_checks++; if (rf_waddr_o !== 5'd3) begin n_fail++; $display("FAIL lsu_prio_addr: got %0d want 3", rf_waddr_o); end
        n_checks++; if (rf_wdata_o !== 32'h3333) begin n_fail++; $display("FAIL lsu_prio_data: got %h want 3333", rf_wdata_o); end
        n_checks++; if (ex_ready_o !== 1'b0) begin n_fail++; $display("FAIL lsu_prio_ex_ready: got %b want 0", ex_ready_o); end
        tick();
        lsu_we_i = 0;
        settle();
        n_checks++; if (rf_waddr_o !== 5'd7) begin n_fail++; $display("FAIL ex_after_lsu_addr: got %0d want 7", rf_waddr_o); end
        n_checks++; if (ex_ready_o !== 1'b1) begin n_fail++; $display("FAIL ex_after_lsu_ready: got %b want 1", ex_ready_o); end
        tick();
        idle();
    endtask

    task automatic test_aux_starvation;
        ex_valid_i = 1; ex_waddr_i = 10; ex_wdata_i = 32'hA;
        aux_valid_i = 1; aux_waddr_i = 11; aux_wdata_i = 32'hB;
        for (int c = 0; c < 6; c++) begin
            settle();
            n_checks++;
            if (aux_ready_o !== (c == MAX_STALL)) begin
                n_fail++; $display("FAIL aux_starve_aux_ready c%0d: got %b want %b", c, aux_ready_o, c == MAX_STALL);
            end
            n_checks++;
            if (ex_ready_o !== (c != MAX_STALL)) begin
                n_fail++; $display("FAIL aux_starve_ex_ready c%0d: got %b want %b", c, ex_ready_o, c != MAX_STALL);
            end
            tick();
        end
        ex_valid_i = 0;
        settle();
        n_checks++; if (aux_ready_o !== 1'b1) begin n_fail++; $display("FAIL aux_drain_ready: got %b want 1", aux_ready_o); end
        tick();
        idle();
    endtask

    task automatic test_waw;
        issue_i = 1; issue_waddr_i = 9;
        tick();
        issue_i = 0;
        settle();
        n_checks++; if (pending_cnt_o !== 6'd1) begin n_fail++; $display("FAIL waw_pre_pending: got %0d want 1", pending_cnt_o); end
        tick();
        issue_i = 1; issue_waddr_i = 9;
        ex_valid_i = 1; ex_waddr_i = 9; ex_wdata_i = 32'h99;
        settle();
        n_checks++; if (ex_ready_o !== 1'b1) begin n_fail++; $display("FAIL waw_ex_ready: got %b want 1", ex_ready_o); end
        tick();
        issue_i = 0; ex_valid_i = 0; raddr_b_i = 9;
        settle();
        n_checks++; if (pending_cnt_o !== 6'd1) begin n_fail++; $display("FAIL waw_pending: got %0d want 1", pending_cnt_o); end
        n_checks++; if (hazard_o !== 1'b1) begin n_fail++; $display("FAIL waw_hazard: got %b want 1", hazard_o); end
        tick();
        ex_valid_i = 1; ex_waddr_i = 9;
        tick();
        idle();
        settle();
        n_checks++; if (pending_cnt_o !== 6'd0) begin n_fail++; $display("FAIL waw_drain_pending: got %0d want 0", pending_cnt_o); end
        tick();
    endtask

    task automatic test_x0;
        ex_valid_i = 1; ex_waddr_i = 0; ex_wdata_i = 32'h1234;
        issue_i = 1; issue_waddr_i = 0;
        settle();
        n_checks++; if (ex_ready_o !== 1'b1) begin n_fail++; $display("FAIL x0_ex_ready: got %b want 1", ex_ready_o); end
        n_checks++; if (rf_we_o !== 1'b0) begin n_fail++; $display("FAIL x0_rf_we: got %b want 0", rf_we_o); end
        tick();
        idle();
        settle();
        n_checks++; if (pending_cnt_o !== 6'd0) begin n_fail++; $display("FAIL x0_pending: got %0d want 0", pending_cnt_o); end
        tick();
    endtask

    task automatic test_reset_midop;
        issue_i = 1; issue_waddr_i = 12;
        ex_valid_i = 1; ex_waddr_i = 20; aux_valid_i = 1; aux_waddr_i = 21;
        tick();
        issue_waddr_i = 13;
        tick();
        issue_i = 0;
        settle();
        n_checks++; if (pending_cnt_o !== 6'd2) begin n_fail++; $display("FAIL midop_pre_pending: got %0d want 2", pending_cnt_o); end
        rst_ni = 1'b0;
        idle();
        raddr_a_i = 12; raddr_b_i = 13;
        #1;
        n_checks++; if (pending_cnt_o !== 6'd0) begin n_fail++; $display("FAIL midop_reset_pending: got %0d want 0", pending_cnt_o); end
        n_checks++; if (hazard_o !== 1'b0) begin n_fail++; $display("FAIL midop_reset_hazard: got %b want 0", hazard_o); end
        tick();
        rst_ni = 1'b1;
        idle();
        tick();
    endtask

    // Reference: pending set of registers and consecutive aux refusal count
    task automatic test_random;
        bit [31:0] m_sb;
        int        m_stall;
        bit        ex_acc, aux_acc;
        int        src;
        logic [4:0]  e_addr;
        logic [31:0] e_data;
        int        e_cnt;
        m_sb = '0; m_stall = 0; ex_acc = 0; aux_acc = 0;
        for (int n = 0; n < 2000; n++) begin
            if (!ex_valid_i || ex_acc) begin
                ex_valid_i = ($urandom % 2) == 0;
                ex_waddr_i = 5'($urandom_range(0, 7));
                ex_wdata_i = $urandom;
            end
            if (!aux_valid_i || aux_acc) begin
                aux_valid_i = ($urandom % 2) == 0;
                aux_waddr_i = 5'($urandom_range(0, 7));
                aux_wdata_i = $urandom;
            end
            lsu_we_i      = ($urandom % 4) == 0;
            lsu_waddr_i   = 5'($urandom_range(0, 7));
            lsu_wdata_i   = $urandom;
            issue_i       = ($urandom % 3) == 0;
            issue_waddr_i = 5'($urandom_range(0, 7));
            raddr_a_i     = 5'($urandom_range(0, 7));
            raddr_b_i     = 5'($urandom_range(0, 7));
            settle();
            // 0 none, 1 lsu, 2 ex, 3 aux
            if (lsu_we_i) src = 1;
            else if (aux_valid_i && (m_stall == MAX_STALL || !ex_valid_i)) src = 3;
            else if (ex_valid_i) src = 2;
            else src = 0;
            e_addr = (src == 1) ? lsu_waddr_i : (src == 2) ? ex_waddr_i : (src == 3) ? aux_waddr_i : 5'd0;
            e_data = (src == 1) ? lsu_wdata_i : (src == 2) ? ex_wdata_i : (src == 3) ? aux_wdata_i : 32'd0;
            e_cnt = 0;
            for (int r = 0; r < 32; r++) e_cnt += int'(m_sb[r]);
            n_checks++; if (ex_ready_o !== (src == 2)) begin n_fail++; $display("FAIL rnd_ex_ready n%0d: got %b want %b", n, ex_ready_o, src == 2); end
            n_checks++; if (aux_ready_o !== (src == 3)) begin n_fail++; $display("FAIL rnd_aux_ready n%0d: got %b want %b", n, aux_ready_o, src == 3); end
            n_checks++; if (rf_we_o !== (src != 0 && e_addr != 0)) begin n_fail++; $display("FAIL rnd_rf_we n%0d: got %b want %b", n, rf_we_o, src != 0 && e_addr != 0); end
            n_checks++; if (rf_waddr_o !== e_addr) begin n_fail++; $display("FAIL rnd_rf_waddr n%0d: got %0d want %0d", n, rf_waddr_o, e_addr); end
            n_checks++; if (rf_wdata_o !== e_data) begin n_fail++; $display("FAIL rnd_rf_wdata n%0d: got %h want %h", n, rf_wdata_o, e_data); end
            n_checks++; if (hazard_o !== (m_sb[raddr_a_i] | m_sb[raddr_b_i])) begin n_fail++; $display("FAIL rnd_hazard n%0d: got %b want %b", n, hazard_o, m_sb[raddr_a_i] | m_sb[raddr_b_i]); end
            n_checks++; if (int'(pending_cnt_o) != e_cnt) begin n_fail++; $display("FAIL rnd_pending n%0d: got %0d want %0d", n, pending_cnt_o, e_cnt); end
            if (src != 0) m_sb[e_addr] = 1'b0;
            if (issue_i && issue_waddr_i != 0) m_sb[issue_waddr_i] = 1'b1;
            if (aux_valid_i && src != 3) m_stall = (m_stall < MAX_STALL) ? m_stall + 1 : MAX_STALL;
            else m_stall = 0;
            ex_acc  = (src == 2);
            aux_acc = (src == 3);
            tick();
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_issue_ex();
        test_lsu_priority();
        test_aux_starvation();
        test_waw();
        test_x0();
        test_reset_midop();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
